// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequences one command through an external combinational ALU and returns a flagged response.
// Define ALU_SEQ_SLT_EN to execute op 101 as set-less-than; otherwise it is rejected as illegal.
module alu_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    output logic             alu_ainvert,
    output logic             alu_bnegate,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_cout,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    output logic             rsp_err
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    localparam logic [2:0] OP_AND = 3'd0, OP_OR = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3, OP_NOR = 3'd4, OP_SLT = 3'd5;
    localparam int MSB = WIDTH - 1;

    state_t           state_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             cmd_ready_q, rsp_valid_q, rsp_cout_q, rsp_zero_q, rsp_ovf_q, rsp_err_q;
    logic [WIDTH-1:0] rsp_result_q, alu_a_q, alu_b_q;
    logic             alu_cin_q, alu_ainv_q, alu_bneg_q;
    logic [2:0]       alu_op_q;

    logic             legal_d, is_sub_d, is_nor_d, add_ovf, sub_ovf, ovf_d, cout_d;
    logic [2:0]       alu_op_d;
    logic [WIDTH-1:0] res_d;

    always_comb begin
`ifdef ALU_SEQ_SLT_EN
        legal_d  = cmd_op <= OP_SLT;
`else
        legal_d  = cmd_op <= OP_NOR;
`endif
        is_sub_d = cmd_op == OP_SUB || cmd_op == OP_SLT;
        is_nor_d = cmd_op == OP_NOR;
        alu_op_d = cmd_op == OP_OR ? 3'b001 : (cmd_op == OP_ADD || is_sub_d) ? 3'b010 : 3'b000;
        // Signs come from the original operands, not the inverted ones the ALU sees.
        add_ovf  = (a_q[MSB] == b_q[MSB]) && (alu_result[MSB] != a_q[MSB]);
        sub_ovf  = (a_q[MSB] != b_q[MSB]) && (alu_result[MSB] != a_q[MSB]);
        res_d    = op_q == OP_SLT ? {{(WIDTH-1){1'b0}}, alu_result[MSB] ^ sub_ovf} : alu_result;
        cout_d   = (op_q == OP_ADD || op_q == OP_SUB || op_q == OP_SLT) && alu_cout;
        ovf_d    = op_q == OP_ADD ? add_ovf : op_q == OP_SUB ? sub_ovf : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_cin_q    <= 1'b0;
            alu_ainv_q   <= 1'b0;
            alu_bneg_q   <= 1'b0;
            alu_op_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (cmd_valid) begin
                    op_q        <= cmd_op;
                    a_q         <= cmd_a;
                    b_q         <= cmd_b;
                    cmd_ready_q <= 1'b0;
                    if (legal_d) begin
                        state_q    <= EXEC;
                        alu_a_q    <= cmd_a;
                        alu_b_q    <= cmd_b;
                        alu_cin_q  <= is_sub_d;
                        alu_ainv_q <= is_nor_d;
                        alu_bneg_q <= is_sub_d || is_nor_d;
                        alu_op_q   <= alu_op_d;
                    end else begin
                        state_q      <= RESP;
                        rsp_valid_q  <= 1'b1;
                        rsp_result_q <= '0;
                        rsp_cout_q   <= 1'b0;
                        rsp_zero_q   <= 1'b1;
                        rsp_ovf_q    <= 1'b0;
                        rsp_err_q    <= 1'b1;
                    end
                end
                EXEC: begin
                    state_q      <= RESP;
                    rsp_valid_q  <= 1'b1;
                    rsp_result_q <= res_d;
                    rsp_cout_q   <= cout_d;
                    rsp_zero_q   <= res_d == '0;
                    rsp_ovf_q    <= ovf_d;
                    rsp_err_q    <= 1'b0;
                    alu_a_q      <= '0;
                    alu_b_q      <= '0;
                    alu_cin_q    <= 1'b0;
                    alu_ainv_q   <= 1'b0;
                    alu_bneg_q   <= 1'b0;
                    alu_op_q     <= '0;
                end
                RESP: if (rsp_ready) begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_cout     = rsp_cout_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_overflow = rsp_ovf_q;
    assign rsp_err      = rsp_err_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_cin      = alu_cin_q;
    assign alu_ainvert  = alu_ainv_q;
    assign alu_bnegate  = alu_bneg_q;
    assign alu_op       = alu_op_q;
endmodule
